// File: rtl/card_pkg.sv
// card_pkg: shared constants, FSM state type and card encoding
// for the blackjack card dealer and downstream hand scoring.
package card_pkg;

    localparam int CARD_W    = 8;
    localparam int DECK_SIZE = 52;
    localparam int RANKS     = 13;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PROBE = 1'b1
    } dealer_state_t;

    // Deck index 0..51 -> {2'b00, suit[1:0], rank[3:0]}, rank 1..13.
    // Subtracting the suit base only on the low nibble is exact
    // because the remainder is always below 16.
    function automatic logic [CARD_W-1:0] card_code(input logic [5:0] idx);
        logic [1:0] s;
        logic [3:0] rk;
        if (idx >= 6'(3*RANKS)) begin
            s  = 2'd3;
            rk = idx[3:0] - 4'((3*RANKS) % 16);
        end else if (idx >= 6'(2*RANKS)) begin
            s  = 2'd2;
            rk = idx[3:0] - 4'((2*RANKS) % 16);
        end else if (idx >= 6'(RANKS)) begin
            s  = 2'd1;
            rk = idx[3:0] - 4'(RANKS % 16);
        end else begin
            s  = 2'd0;
            rk = idx[3:0];
        end
        return {2'b00, s, rk + 4'd1};
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// card_lfsr: free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1.
// Ports: clk_i, rst_i (async, active-low), lfsr_o[15:0]. SEED=0 maps to 1.
module card_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [15:0] lfsr_o
);

    // The all-zero state would lock the register forever.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] TAPS     = 16'hB400;

    logic [15:0] r_lfsr;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_lfsr <= SEED_EFF;
        end else if (r_lfsr[0]) begin
            r_lfsr <= (r_lfsr >> 1) ^ TAPS;
        end else begin
            r_lfsr <= r_lfsr >> 1;
        end
    end

    assign lfsr_o = r_lfsr;

endmodule

// File: rtl/card_dealer.sv
// card_dealer: draws cards without replacement from a 52-card deck.
// Ports: clk_i, rst_i (async low), deal_i, shuffle_i -> card_o[7:0],
// save_o (1-cycle strobe), busy_o, deck_empty_o, cards_left_o[5:0].
// Build option: CARD_DEALER_SEQ_EN deals the deck in index order.
module card_dealer
    import card_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              deal_i,
    input  logic              shuffle_i,
    output logic [CARD_W-1:0] card_o,
    output logic              save_o,
    output logic              busy_o,
    output logic              deck_empty_o,
    output logic [5:0]        cards_left_o
);

    dealer_state_t      r_state;
    logic [5:0]         r_idx;
    logic [DECK_SIZE-1:0] r_used;
    logic [5:0]         r_left;
    logic [CARD_W-1:0]  r_card;
    logic               r_save;

    logic [15:0]        w_lfsr;
    logic [5:0]         w_cand;

    card_lfsr #(
        .SEED   (SEED)
    ) u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .lfsr_o (w_lfsr)
    );

`ifdef CARD_DEALER_SEQ_EN
    // Next undealt position in deck order; probing never advances.
    assign w_cand = 6'(DECK_SIZE) - r_left;
`else
    // Fold 52..63 back onto 0..11.
    assign w_cand = (w_lfsr[5:0] >= 6'(DECK_SIZE)) ?
                    (w_lfsr[5:0] - 6'(DECK_SIZE)) : w_lfsr[5:0];
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_used  <= '0;
            r_left  <= 6'(DECK_SIZE);
            r_card  <= '0;
            r_save  <= 1'b0;
        end else begin
            r_save <= 1'b0;
            if (shuffle_i) begin
                r_used  <= '0;
                r_left  <= 6'(DECK_SIZE);
                r_state <= ST_IDLE;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (deal_i && (r_left != 6'd0)) begin
                            r_idx   <= w_cand;
                            r_state <= ST_PROBE;
                        end
                    end
                    ST_PROBE: begin
                        if (!r_used[r_idx]) begin
                            r_used[r_idx] <= 1'b1;
                            r_card        <= card_code(r_idx);
                            r_save        <= 1'b1;
                            r_left        <= r_left - 6'd1;
                            r_state       <= ST_IDLE;
                        end else if (r_idx == 6'(DECK_SIZE - 1)) begin
                            r_idx <= 6'd0;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign card_o       = r_card;
    assign save_o       = r_save;
    assign cards_left_o = r_left;
    assign busy_o       = (r_state == ST_PROBE);
    assign deck_empty_o = (r_left == 6'd0);

`ifdef CARD_DEALER_SEQ_EN
    logic w_unused;
    assign w_unused = ^w_lfsr;
`endif

endmodule
